sd_cmd_line: RTL
================

SD_CMD_LINE -- requirements
Module: sd_cmd_line

Interface
REQ-001 Parameter RESP_TIMEOUT, default 64: maximum SD_CLK cycles from end of turnaround to response start bit (NCR).
REQ-002 Parameter NCC_GAP, default 8: idle SD_CLK cycles enforced after each transaction before CMD_BUSY drops.
REQ-003 SD_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 CMD_START  in  1  one-cycle request, accepted only while CMD_BUSY=0.
REQ-006 CMD_INDEX  in  6  command index, sampled on accept.
REQ-007 CMD_ARG  in  32  command argument, sampled on accept.
REQ-008 RESP_TYPE  in  2  00 none, 01 R1/R6/R7 (48-bit, CRC), 10 R2 (136-bit), 11 R3 (48-bit, no CRC, index bits all ones); sampled on accept.
REQ-009 CMD_BUSY  out  1  high from accept cycle through end of NCC gap.
REQ-010 CMD_DONE  out  1  one-cycle pulse at end of transaction.
REQ-011 RESP_DATA  out  128  48-bit types: [31:0] = status/argument field, [127:32]=0; R2: response bits 127:0.
REQ-012 ERR_TIMEOUT, ERR_CRC, ERR_INDEX  out  1 each  valid with CMD_DONE, held until next accept.
REQ-013 SD_CMD  inout  1  card command line; driven only in SEND, high-Z otherwise.

Function
REQ-014 Frame sent MSB first, 48 bits: 0, 1, CMD_INDEX, CMD_ARG, CRC7, 1.
REQ-015 CRC7 polynomial x^7+x^3+1, initial 0, over the first 40 frame bits, computed serially during shifting.
REQ-016 States: IDLE, SEND, TURN, WAIT, RECV, CHECK, GAP.
REQ-017 IDLE->SEND on CMD_START with CMD_BUSY=0; first bit on SD_CMD the cycle after accept; CMD_START while busy is ignored.
REQ-018 SEND lasts exactly 48 cycles, then ->GAP if RESP_TYPE=00, else ->TURN.
REQ-019 TURN: 2 cycles, SD_CMD released, then ->WAIT.
REQ-020 WAIT: SD_CMD sampled each cycle; 0 -> RECV (start bit counted as bit 1); counter reaching RESP_TIMEOUT without start bit -> GAP with ERR_TIMEOUT=1.
REQ-021 RECV: collects remaining 47 (types 01/11) or 135 (type 10) bits, then ->CHECK.
REQ-022 CHECK (1 cycle): type 01 -> ERR_CRC if received CRC7 differs from recomputed over first 40 bits, ERR_INDEX if received index differs from CMD_INDEX; type 11 -> ERR_INDEX if index field != 6'h3F, no CRC check; type 10 -> no checks; then ->GAP.
REQ-023 GAP: NCC_GAP cycles, SD_CMD high-Z; CMD_DONE pulses in last GAP cycle; ->IDLE, CMD_BUSY=0 the following cycle.
REQ-024 RESP_DATA updated only in CHECK; unchanged on timeout.
REQ-025 Errors cleared on accept; multiple errors may assert together.

Reset
REQ-026 RST low: immediately release SD_CMD, state IDLE, CMD_BUSY=0, CMD_DONE=0, all errors 0, RESP_DATA=0, counters 0.
REQ-027 RST asserted mid-transaction aborts it without CMD_DONE; first accept after release starts a fresh frame.

Configuration
REQ-028 Macro SD_CMD_RESP_CRC_EN defined: type 01 CRC check per REQ-022.
REQ-029 Macro undefined: no response CRC logic; ERR_CRC tied 0; index check unaffected.

Verification
REQ-030 CMD0, arg 0, type 00 -> SD_CMD bits 48'h400000000095, CMD_DONE 57 cycles after accept (1+48+8), no errors.
REQ-031 CMD8, arg 32'h1AA, type 01, model answers 48'h08000001AA13 -> frame 48'h48000001AA87, RESP_DATA[31:0]=32'h1AA, no errors.
REQ-032 CMD55 type 01, no card response -> ERR_TIMEOUT=1 after 64 WAIT cycles, CMD_DONE pulses once, RESP_DATA unchanged.
REQ-033 CMD8 response with one flipped CRC bit -> ERR_CRC=1 (macro defined) / 0 (undefined); index mismatch 6'd9 -> ERR_INDEX=1.
REQ-034 CMD2 type 10 with 136-bit CID -> RESP_DATA equals bits 127:0; CMD41 type 11 response 48'h3F00FF8000FF -> RESP_DATA[31:0]=32'h00FF8000, no errors.
REQ-035 RST low during SEND bit 20 -> SD_CMD high-Z same cycle, CMD_BUSY=0, no CMD_DONE; new CMD_START after release sends complete frame.

Source files
------------

// File: rtl/sd_cmd_line.sv
// SD card command-line engine: serialises a 48-bit command frame with CRC7 and collects the
// card response. Define SD_CMD_RESP_CRC_EN to enable the CRC7 check on R1/R6/R7 responses.
module sd_cmd_line #(
    parameter int unsigned RESP_TIMEOUT = 64,
    parameter int unsigned NCC_GAP      = 8
) (
    input  logic         sd_clk_i,
    input  logic         rst_ni,
    input  logic         cmd_start_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    output logic         cmd_busy_o,
    output logic         cmd_done_o,
    output logic [127:0] resp_data_o,
    output logic         err_timeout_o,
    output logic         err_crc_o,
    output logic         err_index_o,
    inout  wire          sd_cmd_io
);

    typedef enum logic [2:0] {StIdle, StSend, StTurn, StWait, StRecv, StCheck, StGap} state_e;

    state_e         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [39:0]    frame_q, frame_d;
    logic [6:0]     crc_q, crc_d;
    logic [127:0]   rx_q, rx_d;
    logic [5:0]     idx_q, idx_d;
    logic [1:0]     rtype_q, rtype_d;
    logic [127:0]   resp_q, resp_d;
    logic           err_to_q, err_to_d;
    logic           err_idx_q, err_idx_d;
    logic           tx_bit;
    logic           sd_in;
    logic [15:0]    recv_last;
`ifdef SD_CMD_RESP_CRC_EN
    logic           err_crc_q, err_crc_d;
`endif

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign sd_in     = sd_cmd_io;
    assign sd_cmd_io = (state_q == StSend) ? tx_bit : 1'bz;
    // Start bit was counted in WAIT, so RECV holds the remaining 47 or 135 bits.
    assign recv_last = (rtype_q == 2'b10) ? 16'd134 : 16'd46;

    always_comb begin
        if (cnt_q < 16'd40) begin
            tx_bit = frame_q[39];
        end else if (cnt_q < 16'd47) begin
            tx_bit = crc_q[6];
        end else begin
            tx_bit = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        crc_d      = crc_q;
        rx_d       = rx_q;
        idx_d      = idx_q;
        rtype_d    = rtype_q;
        resp_d     = resp_q;
        err_to_d   = err_to_q;
        err_idx_d  = err_idx_q;
`ifdef SD_CMD_RESP_CRC_EN
        err_crc_d  = err_crc_q;
`endif
        cmd_done_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_start_i) begin
                    state_d   = StSend;
                    cnt_d     = '0;
                    frame_d   = {2'b01, cmd_index_i, cmd_arg_i};
                    crc_d     = '0;
                    idx_d     = cmd_index_i;
                    rtype_d   = resp_type_i;
                    err_to_d  = 1'b0;
                    err_idx_d = 1'b0;
`ifdef SD_CMD_RESP_CRC_EN
                    err_crc_d = 1'b0;
`endif
                end
            end
            StSend: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q < 16'd40) begin
                    frame_d = {frame_q[38:0], 1'b0};
                    crc_d   = crc7_step(crc_q, frame_q[39]);
                end else begin
                    crc_d = {crc_q[5:0], 1'b0};
                end
                if (cnt_q == 16'd47) begin
                    cnt_d   = '0;
                    state_d = (rtype_q == 2'b00) ? StGap : StTurn;
                end
            end
            StTurn: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd1) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sd_in == 1'b0) begin
                    state_d = StRecv;
                    cnt_d   = '0;
                    rx_d    = '0;
                    crc_d   = '0;
                end else if (cnt_q == 16'(RESP_TIMEOUT - 1)) begin
                    state_d  = StGap;
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRecv: begin
                rx_d  = {rx_q[126:0], sd_in};
                cnt_d = cnt_q + 16'd1;
`ifdef SD_CMD_RESP_CRC_EN
                if (cnt_q < 16'd39) begin
                    crc_d = crc7_step(crc_q, sd_in);
                end
`endif
                if (cnt_q == recv_last) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                state_d = StGap;
                case (rtype_q)
                    2'b01: begin
                        resp_d    = {96'b0, rx_q[39:8]};
                        err_idx_d = (rx_q[45:40] != idx_q);
`ifdef SD_CMD_RESP_CRC_EN
                        err_crc_d = (rx_q[7:1] != crc_q);
`endif
                    end
                    2'b11: begin
                        resp_d    = {96'b0, rx_q[39:8]};
                        err_idx_d = (rx_q[45:40] != 6'h3F);
                    end
                    default: resp_d = rx_q;
                endcase
            end
            StGap: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'(NCC_GAP - 1)) begin
                    cmd_done_o = 1'b1;
                    cnt_d      = '0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sd_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            frame_q   <= '0;
            crc_q     <= '0;
            rx_q      <= '0;
            idx_q     <= '0;
            rtype_q   <= '0;
            resp_q    <= '0;
            err_to_q  <= 1'b0;
            err_idx_q <= 1'b0;
`ifdef SD_CMD_RESP_CRC_EN
            err_crc_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            crc_q     <= crc_d;
            rx_q      <= rx_d;
            idx_q     <= idx_d;
            rtype_q   <= rtype_d;
            resp_q    <= resp_d;
            err_to_q  <= err_to_d;
            err_idx_q <= err_idx_d;
`ifdef SD_CMD_RESP_CRC_EN
            err_crc_q <= err_crc_d;
`endif
        end
    end

    assign cmd_busy_o    = (state_q != StIdle);
    assign resp_data_o   = resp_q;
    assign err_timeout_o = err_to_q;
    assign err_index_o   = err_idx_q;
`ifdef SD_CMD_RESP_CRC_EN
    assign err_crc_o     = err_crc_q;
`else
    assign err_crc_o     = 1'b0;
`endif

endmodule
